// File: rtl/btn_pkg.sv
// Shared constants for the push-button debouncer.
// State codes follow Gray order so every legal transition flips one bit.
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE_LO = 2'b00,
      ST_ARM_HI  = 2'b01,
      ST_IDLE_HI = 2'b11,
      ST_ARM_LO  = 2'b10
   } btnState_t;

   localparam int DEBOUNCE_CYCLES_50MHZ = 500000;
   localparam int SIM_DEBOUNCE_CYCLES   = 4;

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-FF synchronizer, qualify FSM and stability counter.
// Outputs are bits of the Gray-coded state register, so they cannot glitch.
module debounce_channel
   import btn_pkg::*;
#(
   parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic raw,
   output logic clean,
   output logic busy
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1;
   logic             s2;
   btnState_t        state;
   btnState_t        stateNxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNxt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= ST_IDLE_LO;
         cnt   <= '0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         state <= stateNxt;
         cnt   <= cntNxt;
      end
   end

   always_comb begin
      stateNxt = state;
      cntNxt   = '0;
      unique case (state)
         ST_IDLE_LO: begin
            if (s2) begin
               stateNxt = ST_ARM_HI;
               cntNxt   = CNT_ONE;
            end
         end
         ST_ARM_HI: begin
            if (!s2)
               stateNxt = ST_IDLE_LO;
            else if (cnt == CNT_LAST)
               stateNxt = ST_IDLE_HI;
            else
               cntNxt = cnt + CNT_ONE;
         end
         ST_IDLE_HI: begin
            if (!s2) begin
               stateNxt = ST_ARM_LO;
               cntNxt   = CNT_ONE;
            end
         end
         ST_ARM_LO: begin
            if (s2)
               stateNxt = ST_IDLE_HI;
            else if (cnt == CNT_LAST)
               stateNxt = ST_IDLE_LO;
            else
               cntNxt = cnt + CNT_ONE;
         end
      endcase
   end

   // bit1 marks the pressed half; the bits differ only in the ARM states
   assign clean = state[1];
   assign busy  = state[1] ^ state[0];

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer feeding the level-to-pulse converters.
// Each channel is independent; raw polarity is normalised to active-high.
module button_debouncer
   import btn_pkg::*;
#(
   parameter int N_BUTTONS     = 4,
   parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
   parameter bit ACTIVE_LOW_IN = 1'b1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [N_BUTTONS-1:0] RawButtonIn,
   output logic [N_BUTTONS-1:0] CleanButtonOut,
   output logic [N_BUTTONS-1:0] ButtonBusy
);

   logic [N_BUTTONS-1:0] level;

   assign level = RawButtonIn ^ {N_BUTTONS{ACTIVE_LOW_IN}};

   for (genvar i = 0; i < N_BUTTONS; i++) begin : gCh
      debounce_channel #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) uCh (
         .CLK  (CLK),
         .RST_N(RST_N),
         .raw  (level[i]),
         .clean(CleanButtonOut[i]),
         .busy (ButtonBusy[i])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: run-length reference model on a scoreboard
// queue, plus directed latency, bounce and asynchronous-reset checks.
module tb_button_debouncer;

   localparam int NB = 4;
   localparam int SC = 4;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [NB-1:0] RawButtonIn = '0;
   logic [NB-1:0] CleanButtonOut;
   logic [NB-1:0] ButtonBusy;

   int nChecks = 0;
   int nFails  = 0;

   button_debouncer #(
      .N_BUTTONS    (NB),
      .STABLE_CYCLES(SC),
      .ACTIVE_LOW_IN(1'b1)
   ) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .RawButtonIn   (RawButtonIn),
      .CleanButtonOut(CleanButtonOut),
      .ButtonBusy    (ButtonBusy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: accepted level flips once the synchronized level has
   // differed from it for SC consecutive edges; busy while that run is open.
   logic [NB-1:0] m1 = '0;
   logic [NB-1:0] m2 = '0;
   logic [NB-1:0] mAcc = '0;
   logic [NB-1:0] mBusy;
   int            mRun[NB];
   logic [7:0]    expQ[$];
   logic [7:0]    e;
   logic [NB-1:0] prevClean = '0;
   int            cyc = 0;
   int            riseCyc[NB];
   int            busyRun1 = 0;
   int            busyMax1 = 0;

   initial
      for (int i = 0; i < NB; i++) begin
         mRun[i]    = 0;
         riseCyc[i] = 0;
      end

   always @(posedge CLK) begin
      cyc++;
      mBusy = '0;
      if (!RST_N) begin
         m1   = '0;
         m2   = '0;
         mAcc = '0;
         for (int i = 0; i < NB; i++) mRun[i] = 0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (m2[i] != mAcc[i]) mRun[i]++;
            else mRun[i] = 0;
            if (mRun[i] == SC) begin
               mAcc[i] = ~mAcc[i];
               mRun[i] = 0;
            end
            mBusy[i] = (mRun[i] != 0);
         end
         m2 = m1;
         m1 = ~RawButtonIn;
      end
      expQ.push_back({mBusy, mAcc});
      #1;
      e = expQ.pop_front();
      chk("sb_clean", CleanButtonOut, e[3:0]);
      chk("sb_busy", ButtonBusy, e[7:4]);
      for (int i = 0; i < NB; i++)
         if (CleanButtonOut[i] && !prevClean[i]) riseCyc[i] = cyc;
      prevClean = CleanButtonOut;
      if (ButtonBusy[1]) busyRun1++;
      else busyRun1 = 0;
      if (busyRun1 > busyMax1) busyMax1 = busyRun1;
   end

   task automatic waitClean(input int b, input logic v, output int n);
      n = 0;
      do begin
         @(posedge CLK);
         #1;
         n++;
      end while (CleanButtonOut[b] !== v && n < 50);
   endtask

   initial begin
      int n;
      RST_N       = 1'b0;
      RawButtonIn = 4'b0000;
      repeat (4) @(negedge CLK);
      chk("rst_clean", CleanButtonOut, 4'h0);
      chk("rst_busy", ButtonBusy, 4'h0);

      // held through reset release: requalified from scratch
      RST_N = 1'b1;
      waitClean(0, 1'b1, n);
      chk("rel_lat", n, 6);
      chk("rel_all", CleanButtonOut, 4'hF);

      @(negedge CLK);
      RawButtonIn = 4'b1111;
      waitClean(0, 1'b0, n);
      chk("fall_lat", n, 6);
      repeat (3) @(negedge CLK);

      // clean press on ch0
      RawButtonIn[0] = 1'b0;
      repeat (2) @(posedge CLK);
      #1 chk("press_busy_k1", ButtonBusy[0], 1'b0);
      @(posedge CLK);
      #1 chk("press_busy_k2", ButtonBusy[0], 1'b1);
      waitClean(0, 1'b1, n);
      chk("press_lat", n, 3);
      chk("press_busy_done", ButtonBusy[0], 1'b0);
      @(negedge CLK);
      RawButtonIn[0] = 1'b1;
      repeat (8) @(negedge CLK);

      // bounce on ch1
      busyMax1 = 0;
      for (int c = 0; c < 40; c++) begin
         if (c % 3 == 0) RawButtonIn[1] = ~RawButtonIn[1];
         @(negedge CLK);
      end
      RawButtonIn[1] = 1'b1;
      repeat (8) @(negedge CLK);
      chk("bnc_clean", CleanButtonOut[1], 1'b0);
      chk("bnc_run_lt4", busyMax1 < SC, 1'b1);
      chk("bnc_busy_seen", busyMax1 > 0, 1'b1);

      // ch2 press, then release with one 2-cycle bounce
      RawButtonIn[2] = 1'b0;
      waitClean(2, 1'b1, n);
      chk("ch2_press_lat", n, 6);
      @(negedge CLK);
      RawButtonIn[2] = 1'b1;
      repeat (2) @(negedge CLK);
      RawButtonIn[2] = 1'b0;
      repeat (2) @(negedge CLK);
      RawButtonIn[2] = 1'b1;
      chk("ch2_hold", CleanButtonOut[2], 1'b1);
      waitClean(2, 1'b0, n);
      chk("ch2_fall_lat", n, 6);
      repeat (3) @(negedge CLK);

      // independence: ch0 and ch3 two cycles apart
      RawButtonIn[0] = 1'b0;
      repeat (2) @(negedge CLK);
      RawButtonIn[3] = 1'b0;
      repeat (10) @(negedge CLK);
      chk("indep_gap", riseCyc[3] - riseCyc[0], 2);
      chk("indep_clean", CleanButtonOut, 4'b1001);
      RawButtonIn = 4'b1111;
      repeat (10) @(negedge CLK);

      // asynchronous reset in the middle of ch0 qualification
      RawButtonIn[0] = 1'b0;
      repeat (4) @(negedge CLK);
      chk("mid_busy", ButtonBusy[0], 1'b1);
      #2 RST_N = 1'b0;
      #1;
      chk("async_busy", ButtonBusy, 4'h0);
      chk("async_clean", CleanButtonOut, 4'h0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      waitClean(0, 1'b1, n);
      chk("requal_lat", n, 6);
      repeat (4) @(negedge CLK);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
